// File: rtl/hvac_mode_scheduler_pkg.sv
// hvac_pkg: shared types, default thresholds and width helper for the HVAC
// mode scheduler.
//   hvac_state_t : FSM state encoding, also exported on the debug port
//   *_DEF        : default thresholds and dwell lengths
//   max3()       : largest of three values, used to size the dwell timer
package hvac_pkg;

    localparam int unsigned TEMP_W  = 5;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        HEAT    = 2'd1,
        COOL    = 2'd2,
        LOCKOUT = 2'd3
    } hvac_state_t;

    localparam int unsigned HEAT_ON_DEF  = 18;
    localparam int unsigned HEAT_OFF_DEF = 20;
    localparam int unsigned COOL_ON_DEF  = 22;
    localparam int unsigned COOL_OFF_DEF = 20;
    localparam int unsigned MIN_ON_DEF   = 4;
    localparam int unsigned MIN_OFF_DEF  = 3;
    localparam int unsigned MAX_RUN_DEF  = 64;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hvac_mode_scheduler_if.sv
// hvac_mode_scheduler_if: control inputs and actuator/status outputs of the
// HVAC mode scheduler.
//   enable, temperature            : driven by the master (temperature pins)
//   heating, cooling, state, fault : driven by the slave (scheduler)
interface hvac_mode_scheduler_if;
    import hvac_pkg::*;

    logic                enable;
    logic [TEMP_W-1:0]   temperature;
    logic                heating;
    logic                cooling;
    hvac_state_t         state;
    logic                fault;

    modport master (
        output enable, temperature,
        input  heating, cooling, state, fault
    );

    modport slave (
        input  enable, temperature,
        output heating, cooling, state, fault
    );

endinterface

// File: rtl/hvac_mode_scheduler_dwell_timer.sv
// hvac_dwell_timer: saturating up-counter measuring cycles spent in the
// current FSM state.
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : zero the count (state change)
//   count         : advance the count by one
//   min_on_done   : MIN_ON cycles spent, counting the current one
//   min_off_done  : MIN_OFF cycles spent, counting the current one
//   max_run_hit   : MAX_RUN cycles spent; constant 0 when MAX_RUN is 0
module hvac_dwell_timer #(
    parameter int unsigned TW      = 3,
    parameter int unsigned MIN_ON  = 4,
    parameter int unsigned MIN_OFF = 3,
    parameter int unsigned MAX_RUN = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic min_on_done,
    output logic min_off_done,
    output logic max_run_hit
);

    logic [TW-1:0] count_q;

    // Saturating counter; holds at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count && (count_q != {TW{1'b1}})) begin
            count_q <= count_q + TW'(1);
        end
    end

    // The count reads 0 during the first cycle in a state, so N cycles are
    // complete (including the current one) once the count reaches N-1.
    assign min_on_done  = (count_q >= TW'(MIN_ON - 1));
    assign min_off_done = (count_q >= TW'(MIN_OFF - 1));
    assign max_run_hit  = (MAX_RUN != 0) && (count_q >= TW'(MAX_RUN - 1));

endmodule

// File: rtl/hvac_mode_scheduler.sv
// hvac_mode_scheduler: heat/cool actuator sequencer with hysteresis, minimum
// run time, post-run lockout and forced stop on enable loss.
//   clk, rst              : clock, asynchronous active-high reset
//   bus.enable            : run permission; low forces both actuators off
//   bus.temperature       : unsigned 5-bit temperature code
//   bus.heating/cooling   : registered actuator drives, decoded from next state
//   bus.state             : current FSM state (debug)
//   bus.fault             : sticky watchdog fault
// Optional feature: define HVAC_WATCHDOG_EN to bound runs to MAX_RUN cycles;
// a tripped watchdog parks the FSM in LOCKOUT with fault=1 until reset.
module hvac_mode_scheduler
    import hvac_pkg::*;
#(
    parameter int unsigned HEAT_ON  = HEAT_ON_DEF,
    parameter int unsigned HEAT_OFF = HEAT_OFF_DEF,
    parameter int unsigned COOL_ON  = COOL_ON_DEF,
    parameter int unsigned COOL_OFF = COOL_OFF_DEF,
    parameter int unsigned MIN_ON   = MIN_ON_DEF,
    parameter int unsigned MIN_OFF  = MIN_OFF_DEF,
    parameter int unsigned MAX_RUN  = MAX_RUN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    hvac_mode_scheduler_if.slave  bus
);

`ifdef HVAC_WATCHDOG_EN
    localparam bit          WATCHDOG_EN = 1'b1;
`else
    localparam bit          WATCHDOG_EN = 1'b0;
`endif
    // Without the watchdog the run limit is zero, so it neither sizes the
    // timer nor ever fires.
    localparam int unsigned RUN_LIMIT = WATCHDOG_EN ? MAX_RUN : 0;
    localparam int unsigned TW        = $clog2(max3(MIN_ON, MIN_OFF, RUN_LIMIT) + 1);

    localparam logic [TEMP_W-1:0] HEAT_ON_T  = TEMP_W'(HEAT_ON);
    localparam logic [TEMP_W-1:0] HEAT_OFF_T = TEMP_W'(HEAT_OFF);
    localparam logic [TEMP_W-1:0] COOL_ON_T  = TEMP_W'(COOL_ON);
    localparam logic [TEMP_W-1:0] COOL_OFF_T = TEMP_W'(COOL_OFF);

    hvac_state_t state_q, state_d;
    logic        heating_q, heating_d;
    logic        cooling_q, cooling_d;
    logic        fault_q, fault_d;
    logic        min_on_done, min_off_done, max_run_hit;

    hvac_dwell_timer #(
        .TW      (TW),
        .MIN_ON  (MIN_ON),
        .MIN_OFF (MIN_OFF),
        .MAX_RUN (RUN_LIMIT)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (state_d != state_q),
        .count        (1'b1),
        .min_on_done  (min_on_done),
        .min_off_done (min_off_done),
        .max_run_hit  (max_run_hit)
    );

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            heating_q <= 1'b0;
            cooling_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            heating_q <= heating_d;
            cooling_q <= cooling_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state logic; heat<->cool always passes through LOCKOUT and IDLE
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (bus.enable && (bus.temperature <= HEAT_ON_T)) begin
                    state_d = HEAT;
                end else if (bus.enable && (bus.temperature >= COOL_ON_T)) begin
                    state_d = COOL;
                end
            end
            HEAT: begin
                if (!bus.enable) begin
                    state_d = LOCKOUT;
                end else if (max_run_hit) begin
                    state_d = LOCKOUT;
`ifdef HVAC_WATCHDOG_EN
                    fault_d = 1'b1;
`endif
                end else if (min_on_done && (bus.temperature >= HEAT_OFF_T)) begin
                    state_d = LOCKOUT;
                end
            end
            COOL: begin
                if (!bus.enable) begin
                    state_d = LOCKOUT;
                end else if (max_run_hit) begin
                    state_d = LOCKOUT;
`ifdef HVAC_WATCHDOG_EN
                    fault_d = 1'b1;
`endif
                end else if (min_on_done && (bus.temperature <= COOL_OFF_T)) begin
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                // A latched fault pins the FSM here until reset
                if (!fault_q && min_off_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Actuator decode from next state, so outputs track the decision edge
    always_comb begin
        heating_d = (state_d == HEAT);
        cooling_d = (state_d == COOL);
    end

    assign bus.heating = heating_q;
    assign bus.cooling = cooling_q;
    assign bus.state   = state_q;
    assign bus.fault   = fault_q;

endmodule

// File: tb/tb_hvac_mode_scheduler.sv
// Scoreboard bench for hvac_mode_scheduler: stimulus pushes hand-computed
// expectations, a monitor pops and compares them after each rising edge
// (or right after an asynchronous reset assertion).
module tb_hvac_mode_scheduler;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAT = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;
    localparam logic [1:0] S_LOCK = 2'd3;

    typedef struct {
        string      name;
        logic       h;
        logic       c;
        logic [1:0] s;
        logic       f;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hvac_mode_scheduler_if bus();

    hvac_mode_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    event chk_now;

    // Monitor: compare one expectation per rising edge or async-reset probe
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_now);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.heating !== e.h || bus.cooling !== e.c ||
                    2'(bus.state) !== e.s || bus.fault !== e.f) begin
                    failures++;
                    $display("FAIL %s: got heating=%b cooling=%b state=%0d fault=%b, required heating=%b cooling=%b state=%0d fault=%b",
                             e.name, bus.heating, bus.cooling, 2'(bus.state), bus.fault,
                             e.h, e.c, e.s, e.f);
                end
            end
        end
    end

    task automatic step(input logic en, input logic [4:0] t, input string nm,
                        input logic h, input logic c, input logic [1:0] s,
                        input logic f);
        @(negedge clk);
        rst             = 1'b0;
        bus.enable      = en;
        bus.temperature = t;
        sb.push_back('{nm, h, c, s, f});
    endtask

    task automatic async_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        sb.push_back('{nm, 1'b0, 1'b0, S_IDLE, 1'b0});
        -> chk_now;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable      = 1'b1;
        bus.temperature = 5'd10;

        // Reset held, then release into a heat call
        repeat (2) @(negedge clk);
        sb.push_back('{"reset_hold", 1'b0, 1'b0, S_IDLE, 1'b0});
        -> chk_now;
        step(1, 10, "rst_release", 1, 0, S_HEAT, 0);
        step(1, 10, "heat_run",    1, 0, S_HEAT, 0);
        async_reset("rst_async");
        step(0, 20, "idle_after_rst", 0, 0, S_IDLE, 0);

        // Heat hysteresis ramp 15..25
        step(1, 15, "ramp15",      1, 0, S_HEAT, 0);
        step(1, 16, "ramp16",      1, 0, S_HEAT, 0);
        step(1, 17, "ramp17",      1, 0, S_HEAT, 0);
        step(1, 18, "ramp18",      1, 0, S_HEAT, 0);
        step(1, 19, "ramp19_hold", 1, 0, S_HEAT, 0);
        step(1, 20, "ramp20_off",  0, 0, S_LOCK, 0);
        step(1, 21, "ramp21_lock", 0, 0, S_LOCK, 0);
        step(1, 22, "ramp22_lock", 0, 0, S_LOCK, 0);
        step(1, 23, "ramp23_idle", 0, 0, S_IDLE, 0);
        step(1, 24, "ramp24_cool", 0, 1, S_COOL, 0);

        // Enable drop in the first cycle of a cool run
        step(0, 25, "en_drop",         0, 0, S_LOCK, 0);
        step(0, 25, "en_lock2",        0, 0, S_LOCK, 0);
        step(0, 25, "en_lock3",        0, 0, S_LOCK, 0);
        step(0, 25, "en_idle",         0, 0, S_IDLE, 0);
        step(0, 25, "no_reentry_hot",  0, 0, S_IDLE, 0);
        step(0,  5, "no_reentry_cold", 0, 0, S_IDLE, 0);

        // Minimum run: one cold sample, then hot
        step(1, 18, "minrun_start", 1, 0, S_HEAT, 0);
        step(1, 25, "minrun_2",     1, 0, S_HEAT, 0);
        step(1, 25, "minrun_3",     1, 0, S_HEAT, 0);
        step(1, 25, "minrun_4",     1, 0, S_HEAT, 0);
        step(1, 25, "minrun_end",   0, 0, S_LOCK, 0);
        step(1, 25, "minrun_lock2", 0, 0, S_LOCK, 0);
        step(1, 25, "minrun_lock3", 0, 0, S_LOCK, 0);
        step(1, 25, "minrun_idle",  0, 0, S_IDLE, 0);
        step(1, 25, "minrun_cool",  0, 1, S_COOL, 0);

        // Cool run ends at COOL_OFF, then 31 applied during lockout
        step(1, 25, "cool_2",           0, 1, S_COOL, 0);
        step(1, 25, "cool_3",           0, 1, S_COOL, 0);
        step(1, 25, "cool_4",           0, 1, S_COOL, 0);
        step(1, 20, "cool_end",         0, 0, S_LOCK, 0);
        step(1, 31, "lock_ignore_1",    0, 0, S_LOCK, 0);
        step(1, 31, "lock_ignore_2",    0, 0, S_LOCK, 0);
        step(1, 31, "lock_ignore_idle", 0, 0, S_IDLE, 0);
        step(1, 31, "lock_ignore_cool", 0, 1, S_COOL, 0);
        step(0, 31, "cool_en_drop",     0, 0, S_LOCK, 0);
        step(0, 31, "cool_drop_lock2",  0, 0, S_LOCK, 0);
        step(0, 31, "cool_drop_lock3",  0, 0, S_LOCK, 0);
        step(0, 31, "cool_drop_idle",   0, 0, S_IDLE, 0);

        // Threshold boundaries
        step(1, 19, "idle19",       0, 0, S_IDLE, 0);
        step(1, 21, "idle21",       0, 0, S_IDLE, 0);
        step(1, 22, "cool_on22",    0, 1, S_COOL, 0);
        step(1, 21, "cool21_a",     0, 1, S_COOL, 0);
        step(1, 21, "cool21_b",     0, 1, S_COOL, 0);
        step(1, 21, "cool21_c",     0, 1, S_COOL, 0);
        step(1, 21, "cool_hold21",  0, 1, S_COOL, 0);
        step(1, 20, "cool_off20",   0, 0, S_LOCK, 0);
        step(1, 20, "b_lock2",      0, 0, S_LOCK, 0);
        step(1, 20, "b_lock3",      0, 0, S_LOCK, 0);
        step(1, 20, "b_idle20",     0, 0, S_IDLE, 0);
        step(1,  0, "heat_code0",   1, 0, S_HEAT, 0);
        step(0,  0, "code0_drop",   0, 0, S_LOCK, 0);
        step(0,  0, "code0_lock2",  0, 0, S_LOCK, 0);
        step(0,  0, "code0_lock3",  0, 0, S_LOCK, 0);
        step(0,  0, "code0_idle",   0, 0, S_IDLE, 0);

`ifdef HVAC_WATCHDOG_EN
        // Watchdog: 64-cycle run limit, sticky fault until reset
        step(1, 5, "wd_start", 1, 0, S_HEAT, 0);
        for (int i = 1; i < 64; i++) step(1, 5, "wd_run", 1, 0, S_HEAT, 0);
        step(1, 5, "wd_trip", 0, 0, S_LOCK, 1);
        for (int i = 0; i < 200; i++) step(1, 5, "wd_hold", 0, 0, S_LOCK, 1);
        async_reset("wd_rst");
        step(1, 5, "wd_recover", 1, 0, S_HEAT, 0);
`else
        // Without the watchdog a cold run is unbounded
        step(1, 5, "run_start", 1, 0, S_HEAT, 0);
        for (int i = 0; i < 99; i++) step(1, 5, "run_unbounded", 1, 0, S_HEAT, 0);
`endif

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
